// File: rtl/param_counter_pkg.sv
// ---------------------------------------------------------------------------
// param_counter_pkg
// Shared definitions for the param_counter block:
//   mode_e          wrap / saturate boundary behaviour
//   *_MIN / *_MAX   legal ranges for WIDTH and PRESCALE
//   DEFAULT_*       default parameter values
//   max_for_width() largest value representable in a given width
// ---------------------------------------------------------------------------
package param_counter_pkg;

  typedef enum logic {
    MODE_WRAP     = 1'b0,
    MODE_SATURATE = 1'b1
  } mode_e;

  localparam int WIDTH_MIN        = 2;
  localparam int WIDTH_MAX        = 32;
  localparam int PRESCALE_MIN     = 2;
  localparam int PRESCALE_MAX     = 256;
  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_PRESCALE = 4;

  // 2**w - 1 computed in 64 bits so w = 32 does not overflow.
  function automatic logic [63:0] max_for_width(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/param_counter_if.sv
// ---------------------------------------------------------------------------
// param_counter_if
// Control and status bundle of param_counter.
//   en, up, clr, load, load_val, ovf_clr : driven by the master (user logic)
//   cnt, tc, ovf                         : driven by the slave (the counter)
// WIDTH must match the WIDTH parameter of the attached counter.
// ---------------------------------------------------------------------------
interface param_counter_if
  import param_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             en;
  logic             up;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             ovf_clr;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             ovf;

  modport master (
    output en, up, clr, load, load_val, ovf_clr,
    input  cnt, tc, ovf
  );

  modport slave (
    input  en, up, clr, load, load_val, ovf_clr,
    output cnt, tc, ovf
  );

endinterface

// File: rtl/param_counter_prescaler.sv
// ---------------------------------------------------------------------------
// param_counter_prescaler
// Counts enabled cycles and raises tick on every PRESCALE-th one, then wraps.
// Only instantiated when PARAM_COUNTER_PRESCALE_EN is defined.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   en       count enable (only en=1 cycles advance the window)
//   restart  clears the window (driven by the counter's clr | load)
//   tick     combinational, 1 on the last cycle of a window while en=1
// ---------------------------------------------------------------------------
module param_counter_prescaler
  import param_counter_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int            PW   = $clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [PW-1:0] pcnt_q;

  assign tick = en & (pcnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      pcnt_q <= '0;
    end else if (en) begin
      pcnt_q <= tick ? '0 : pcnt_q + ONE;
    end
  end

endmodule

// File: rtl/param_counter.sv
// ---------------------------------------------------------------------------
// param_counter
// Up/down counter with wrap or saturate at 0 and MAX, clamped load, sticky
// overflow flag and a one-cycle terminal-count pulse.
// Optional feature: define PARAM_COUNTER_PRESCALE_EN to insert a prescaler so
// that only every PRESCALE-th enabled cycle steps the count.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  param_counter_if.slave (en, up, clr, load, load_val, ovf_clr in;
//        cnt, tc, ovf out, all outputs registered)
// Update priority per edge: rst > clr > load > step.
// ---------------------------------------------------------------------------
module param_counter
  import param_counter_pkg::*;
#(
  parameter int              WIDTH    = DEFAULT_WIDTH,
  parameter longint unsigned MAX      = max_for_width(WIDTH),
  parameter int              SATURATE = 0,
  parameter int              PRESCALE = DEFAULT_PRESCALE
) (
  input  logic                clk,
  input  logic                rst,
  param_counter_if.slave      bus
);

  // ---- parameter legality, rejected at elaboration ----
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("param_counter: WIDTH=%0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
  end
  if (MAX < 1 || MAX > max_for_width(WIDTH)) begin : g_bad_max
    $error("param_counter: MAX=%0d outside 1..2**WIDTH-1", MAX);
  end
  if (SATURATE != 0 && SATURATE != 1) begin : g_bad_saturate
    $error("param_counter: SATURATE=%0d must be 0 or 1", SATURATE);
  end
  if (PRESCALE < PRESCALE_MIN || PRESCALE > PRESCALE_MAX) begin : g_bad_prescale
    $error("param_counter: PRESCALE=%0d outside %0d..%0d", PRESCALE, PRESCALE_MIN, PRESCALE_MAX);
  end

  localparam mode_e          MODE    = (SATURATE != 0) ? MODE_SATURATE : MODE_WRAP;
  // All arithmetic runs one bit wider than the count so MAX = 2**WIDTH-1
  // compares and increments without truncation.
  localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);

  logic [WIDTH-1:0] cnt_q;
  logic             tc_q;
  logic             ovf_q;

  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   load_ext;
  logic [WIDTH:0]   next_ext;
  logic             clamp;
  logic             boundary;
  logic             ovf_set;
  logic             tick;
  logic             unused_carry;

  // ---- step qualifier ----
`ifdef PARAM_COUNTER_PRESCALE_EN
  logic restart;
  assign restart = bus.clr | bus.load;

  param_counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en      (bus.en),
    .restart (restart),
    .tick    (tick)
  );
`else
  assign tick = 1'b1;
`endif

  // ---- next-state computation ----
  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    cnt_ext  = {1'b0, cnt_q};
    load_ext = {1'b0, bus.load_val};
    clamp    = load_ext > MAX_EXT;
    boundary = 1'b0;
    ovf_set  = 1'b0;
    next_ext = cnt_ext;

    if (bus.clr) begin
      next_ext = '0;
    end else if (bus.load) begin
      next_ext = clamp ? MAX_EXT : load_ext;
      ovf_set  = clamp;
    end else if (bus.en && tick) begin
      if (bus.up) begin
        if (cnt_ext == MAX_EXT) begin
          // In saturate mode a held count still reports every attempt.
          boundary = 1'b1;
          next_ext = (MODE == MODE_SATURATE) ? MAX_EXT : '0;
        end else begin
          next_ext = cnt_ext + ONE_EXT;
        end
      end else begin
        if (cnt_ext == '0) begin
          boundary = 1'b1;
          next_ext = (MODE == MODE_SATURATE) ? '0 : MAX_EXT;
        end else begin
          next_ext = cnt_ext - ONE_EXT;
        end
      end
      ovf_set = boundary;
    end
  end

  // next_ext never exceeds MAX, so its top bit is always zero.
  assign unused_carry = next_ext[WIDTH];

  // ---- state ----
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop in
    // the block samples the pre-edge values.
    if (rst) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= next_ext[WIDTH-1:0];
      tc_q  <= boundary;
      // A new set beats a simultaneous ovf_clr.
      ovf_q <= ovf_set | (ovf_q & ~bus.ovf_clr);
    end
  end

  assign bus.cnt = cnt_q;
  assign bus.tc  = tc_q;
  assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_param_counter.sv
// ---------------------------------------------------------------------------
// tb_param_counter
// Drives one wrapping (SATURATE=0) and one saturating (SATURATE=1) counter,
// WIDTH=8, MAX=9, with identical stimulus and compares both against an
// integer reference model. Works with or without PARAM_COUNTER_PRESCALE_EN.
// ---------------------------------------------------------------------------
module tb_param_counter;

  localparam int WIDTH    = 8;
  localparam int MAX      = 9;
  localparam int PRESCALE = 4;
`ifdef PARAM_COUNTER_PRESCALE_EN
  localparam int CYC = PRESCALE;
`else
  localparam int CYC = 1;
`endif

  typedef struct {
    int cnt;
    bit tc;
    bit ovf;
    int pre;
  } model_t;

  logic   clk;
  logic   rst;
  int     checks;
  int     errors;
  model_t m_w;
  model_t m_s;

  param_counter_if #(.WIDTH(WIDTH)) w_if ();
  param_counter_if #(.WIDTH(WIDTH)) s_if ();

  assign s_if.en       = w_if.en;
  assign s_if.up       = w_if.up;
  assign s_if.clr      = w_if.clr;
  assign s_if.load     = w_if.load;
  assign s_if.load_val = w_if.load_val;
  assign s_if.ovf_clr  = w_if.ovf_clr;

  param_counter #(.WIDTH(WIDTH), .MAX(MAX), .SATURATE(0), .PRESCALE(PRESCALE)) u_wrap (
    .clk (clk),
    .rst (rst),
    .bus (w_if)
  );

  param_counter #(.WIDTH(WIDTH), .MAX(MAX), .SATURATE(1), .PRESCALE(PRESCALE)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one edge of the counter, from the behavioural rules.
  function automatic model_t mnext(input model_t m, input bit sat, input bit r, input bit en,
                                   input bit up, input bit clr, input bit load, input int lv,
                                   input bit oc);
    model_t n;
    bit tick;
    bit hit;
    bit set;
    n    = m;
    hit  = 1'b0;
    set  = 1'b0;
    if (r) begin
      n.cnt = 0; n.tc = 1'b0; n.ovf = 1'b0; n.pre = 0;
      return n;
    end
`ifdef PARAM_COUNTER_PRESCALE_EN
    tick = 1'b0;
    if (clr || load) n.pre = 0;
    else if (en) begin
      n.pre = m.pre + 1;
      if (n.pre == PRESCALE) begin tick = 1'b1; n.pre = 0; end
    end
`else
    tick = 1'b1;
`endif
    if (clr) n.cnt = 0;
    else if (load) begin
      if (lv > MAX) begin n.cnt = MAX; set = 1'b1; end
      else n.cnt = lv;
    end else if (en && tick) begin
      if (up) begin
        if (m.cnt + 1 > MAX) begin hit = 1'b1; n.cnt = sat ? MAX : 0; end
        else n.cnt = m.cnt + 1;
      end else begin
        if (m.cnt - 1 < 0) begin hit = 1'b1; n.cnt = sat ? 0 : MAX; end
        else n.cnt = m.cnt - 1;
      end
    end
    n.tc  = hit;
    n.ovf = (hit || set) ? 1'b1 : (oc ? 1'b0 : m.ovf);
    return n;
  endfunction

  // One clock: drive inputs, take the edge, advance both models, settle.
  task automatic apply(input bit r, input bit en, input bit up, input bit clr,
                       input bit load, input int lv, input bit oc);
    rst           = r;
    w_if.en       = en;
    w_if.up       = up;
    w_if.clr      = clr;
    w_if.load     = load;
    w_if.load_val = WIDTH'(lv);
    w_if.ovf_clr  = oc;
    @(posedge clk);
    m_w = mnext(m_w, 1'b0, r, en, up, clr, load, lv, oc);
    m_s = mnext(m_s, 1'b1, r, en, up, clr, load, lv, oc);
    #1;
  endtask

  // One full step (CYC enabled cycles); ovf_clr only on the stepping cycle.
  task automatic do_step(input bit up, input bit oc_last);
    for (int i = 0; i < CYC; i++) apply(1'b0, 1'b1, up, 1'b0, 1'b0, 0, oc_last && (i == CYC - 1));
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++)
      apply(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 255)), 1'($urandom));
    checks++; if (w_if.cnt !== 8'd0) begin errors++; $display("FAIL reset w.cnt: got %0d expected 0", w_if.cnt); end
    checks++; if (w_if.tc !== 1'b0) begin errors++; $display("FAIL reset w.tc: got %0b expected 0", w_if.tc); end
    checks++; if (w_if.ovf !== 1'b0) begin errors++; $display("FAIL reset w.ovf: got %0b expected 0", w_if.ovf); end
    checks++; if (s_if.cnt !== 8'd0) begin errors++; $display("FAIL reset s.cnt: got %0d expected 0", s_if.cnt); end
    checks++; if (s_if.tc !== 1'b0) begin errors++; $display("FAIL reset s.tc: got %0b expected 0", s_if.tc); end
    checks++; if (s_if.ovf !== 1'b0) begin errors++; $display("FAIL reset s.ovf: got %0b expected 0", s_if.ovf); end
  endtask

  task automatic test_wrap_up();
    int exp_cnt;
    bit exp_tc;
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      do_step(1'b1, 1'b0);
      exp_cnt = (i + 1) % (MAX + 1);
      exp_tc  = (i == MAX);
      checks++; if (w_if.cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL wrap_up cnt step %0d: got %0d expected %0d", i, w_if.cnt, exp_cnt); end
      checks++; if (w_if.tc !== exp_tc) begin errors++; $display("FAIL wrap_up tc step %0d: got %0b expected %0b", i, w_if.tc, exp_tc); end
    end
    checks++; if (w_if.ovf !== 1'b1) begin errors++; $display("FAIL wrap_up ovf: got %0b expected 1", w_if.ovf); end
  endtask

  task automatic test_saturate();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, MAX, 1'b1);
    checks++; if (s_if.cnt !== 8'(MAX)) begin errors++; $display("FAIL sat load cnt: got %0d expected %0d", s_if.cnt, MAX); end
    checks++; if (s_if.ovf !== 1'b0) begin errors++; $display("FAIL sat load ovf: got %0b expected 0", s_if.ovf); end
    for (int i = 0; i < 3; i++) begin
      do_step(1'b1, 1'b0);
      checks++; if (s_if.cnt !== 8'(MAX)) begin errors++; $display("FAIL sat hold cnt %0d: got %0d expected %0d", i, s_if.cnt, MAX); end
      checks++; if (s_if.tc !== 1'b1) begin errors++; $display("FAIL sat hold tc %0d: got %0b expected 1", i, s_if.tc); end
      checks++; if (w_if.cnt !== 8'(i)) begin errors++; $display("FAIL sat wrap cnt %0d: got %0d expected %0d", i, w_if.cnt, i); end
    end
    checks++; if (s_if.ovf !== 1'b1) begin errors++; $display("FAIL sat ovf: got %0b expected 1", s_if.ovf); end
  endtask

  task automatic test_down_wrap();
    apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b1);
    checks++; if (w_if.cnt !== 8'd0) begin errors++; $display("FAIL down clr cnt: got %0d expected 0", w_if.cnt); end
    checks++; if (w_if.tc !== 1'b0) begin errors++; $display("FAIL down clr tc: got %0b expected 0", w_if.tc); end
    checks++; if (w_if.ovf !== 1'b0) begin errors++; $display("FAIL down clr ovf: got %0b expected 0", w_if.ovf); end
    do_step(1'b0, 1'b0);
    checks++; if (w_if.cnt !== 8'(MAX)) begin errors++; $display("FAIL down wrap cnt: got %0d expected %0d", w_if.cnt, MAX); end
    checks++; if (w_if.tc !== 1'b1) begin errors++; $display("FAIL down wrap tc: got %0b expected 1", w_if.tc); end
    checks++; if (w_if.ovf !== 1'b1) begin errors++; $display("FAIL down wrap ovf: got %0b expected 1", w_if.ovf); end
    checks++; if (s_if.cnt !== 8'd0) begin errors++; $display("FAIL down sat cnt: got %0d expected 0", s_if.cnt); end
    checks++; if (s_if.tc !== 1'b1) begin errors++; $display("FAIL down sat tc: got %0b expected 1", s_if.tc); end
    do_step(1'b0, 1'b1);
    checks++; if (s_if.ovf !== 1'b1) begin errors++; $display("FAIL down set-beats-clr s.ovf: got %0b expected 1", s_if.ovf); end
    checks++; if (s_if.tc !== 1'b1) begin errors++; $display("FAIL down repeat s.tc: got %0b expected 1", s_if.tc); end
    checks++; if (w_if.cnt !== 8'(MAX - 1)) begin errors++; $display("FAIL down w.cnt: got %0d expected %0d", w_if.cnt, MAX - 1); end
    checks++; if (w_if.ovf !== 1'b0) begin errors++; $display("FAIL down ovf_clr w.ovf: got %0b expected 0", w_if.ovf); end
  endtask

  task automatic test_load();
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 200, 1'b0);
    checks++; if (w_if.cnt !== 8'(MAX)) begin errors++; $display("FAIL load clamp cnt: got %0d expected %0d", w_if.cnt, MAX); end
    checks++; if (w_if.ovf !== 1'b1) begin errors++; $display("FAIL load clamp ovf: got %0b expected 1", w_if.ovf); end
    checks++; if (w_if.tc !== 1'b0) begin errors++; $display("FAIL load clamp tc: got %0b expected 0", w_if.tc); end
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4, 1'b1);
    checks++; if (w_if.cnt !== 8'd4) begin errors++; $display("FAIL load over en cnt: got %0d expected 4", w_if.cnt); end
    checks++; if (s_if.ovf !== 1'b0) begin errors++; $display("FAIL load ovf_clr s.ovf: got %0b expected 0", s_if.ovf); end
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, MAX + 1, 1'b0);
    checks++; if (s_if.cnt !== 8'(MAX)) begin errors++; $display("FAIL load MAX+1 cnt: got %0d expected %0d", s_if.cnt, MAX); end
    checks++; if (s_if.ovf !== 1'b1) begin errors++; $display("FAIL load MAX+1 ovf: got %0b expected 1", s_if.ovf); end
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, MAX, 1'b1);
    checks++; if (w_if.cnt !== 8'(MAX)) begin errors++; $display("FAIL load MAX cnt: got %0d expected %0d", w_if.cnt, MAX); end
    checks++; if (w_if.ovf !== 1'b0) begin errors++; $display("FAIL load MAX ovf: got %0b expected 0", w_if.ovf); end
  endtask

  task automatic test_reset_mid();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 200, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5, 1'b0);
    checks++; if (w_if.cnt !== 8'd5 || w_if.ovf !== 1'b1) begin errors++; $display("FAIL mid pre cnt/ovf: got %0d/%0b expected 5/1", w_if.cnt, w_if.ovf); end
    apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7, 1'b0);
    checks++; if (w_if.cnt !== 8'd0) begin errors++; $display("FAIL mid rst cnt: got %0d expected 0", w_if.cnt); end
    checks++; if (w_if.ovf !== 1'b0) begin errors++; $display("FAIL mid rst ovf: got %0b expected 0", w_if.ovf); end
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, MAX, 1'b0);
    for (int i = 0; i < CYC - 1; i++) apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    checks++; if (w_if.tc !== 1'b0) begin errors++; $display("FAIL mid rst tc: got %0b expected 0", w_if.tc); end
    checks++; if (s_if.tc !== 1'b0) begin errors++; $display("FAIL mid rst s.tc: got %0b expected 0", s_if.tc); end
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6, 1'b0);
    checks++; if (w_if.cnt !== 8'd0) begin errors++; $display("FAIL mid clr+load cnt: got %0d expected 0", w_if.cnt); end
  endtask

`ifdef PARAM_COUNTER_PRESCALE_EN
  task automatic test_prescale();
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      checks++; if (w_if.cnt !== 8'(i / PRESCALE)) begin errors++; $display("FAIL prescale cnt cycle %0d: got %0d expected %0d", i, w_if.cnt, i / PRESCALE); end
    end
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    for (int i = 0; i < PRESCALE - 1; i++) apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    checks++; if (w_if.cnt !== 8'd0) begin errors++; $display("FAIL prescale restart early: got %0d expected 0", w_if.cnt); end
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    checks++; if (w_if.cnt !== 8'd1) begin errors++; $display("FAIL prescale restart step: got %0d expected 1", w_if.cnt); end
  endtask
`endif

  task automatic test_random();
    int lv;
    for (int i = 0; i < 600; i++) begin
      lv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, MAX + 3));
      apply($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
            $urandom_range(0, 29) == 0, $urandom_range(0, 14) == 0, lv, $urandom_range(0, 7) == 0);
      checks++; if (w_if.cnt !== 8'(m_w.cnt)) begin errors++; $display("FAIL random w.cnt @%0d: got %0d expected %0d", i, w_if.cnt, m_w.cnt); end
      checks++; if (w_if.tc !== m_w.tc) begin errors++; $display("FAIL random w.tc @%0d: got %0b expected %0b", i, w_if.tc, m_w.tc); end
      checks++; if (w_if.ovf !== m_w.ovf) begin errors++; $display("FAIL random w.ovf @%0d: got %0b expected %0b", i, w_if.ovf, m_w.ovf); end
      checks++; if (s_if.cnt !== 8'(m_s.cnt)) begin errors++; $display("FAIL random s.cnt @%0d: got %0d expected %0d", i, s_if.cnt, m_s.cnt); end
      checks++; if (s_if.tc !== m_s.tc) begin errors++; $display("FAIL random s.tc @%0d: got %0b expected %0b", i, s_if.tc, m_s.tc); end
      checks++; if (s_if.ovf !== m_s.ovf) begin errors++; $display("FAIL random s.ovf @%0d: got %0b expected %0b", i, s_if.ovf, m_s.ovf); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_w    = '{cnt: 0, tc: 1'b0, ovf: 1'b0, pre: 0};
    m_s    = '{cnt: 0, tc: 1'b0, ovf: 1'b0, pre: 0};
    test_reset();
    test_wrap_up();
    test_saturate();
    test_down_wrap();
    test_load();
    test_reset_mid();
`ifdef PARAM_COUNTER_PRESCALE_EN
    test_prescale();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 Parameter MAX, default 2**WIDTH-1: terminal value, legal range 1..2**WIDTH-1.
REQ-003 Parameter SATURATE, default 0: 0 = wrap at boundary, 1 = hold at boundary.
REQ-004 Parameter PRESCALE, default 4: enabled cycles per step, legal range 2..256; used only when prescaling is compiled in.
REQ-005 clk  in  1  single clock, all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 en  in  1  count enable.
REQ-008 up  in  1  direction: 1 = increment, 0 = decrement.
REQ-009 clr  in  1  synchronous clear of the count.
REQ-010 load  in  1  load strobe.
REQ-011 load_val  in  WIDTH  value loaded when load=1.
REQ-012 ovf_clr  in  1  clears the sticky overflow flag.
REQ-013 cnt  out  WIDTH  registered count.
REQ-014 tc  out  1  registered one-cycle terminal-count pulse.
REQ-015 ovf  out  1  sticky boundary/overflow flag.

Function
REQ-016 The update priority on each edge SHALL be rst > clr > load > step.
REQ-017 A step SHALL occur on an edge where en=1, clr=0, load=0 and tick=1; tick SHALL be 1 when prescaling is compiled out.
REQ-018 The cnt value SHALL reflect a step, load or clear on the edge that samples it (one-cycle latency).
REQ-019 An up step SHALL give cnt+1 when cnt<MAX, and 0 (SATURATE=0) or MAX (SATURATE=1) when cnt=MAX.
REQ-020 A down step SHALL give cnt-1 when cnt>0, and MAX (SATURATE=0) or 0 (SATURATE=1) when cnt=0.
REQ-021 A boundary event is any step taken from MAX going up or from 0 going down; tc SHALL be 1 for exactly the cycle after each boundary event, else 0.
REQ-022 In saturate mode, every step attempted while held at the boundary SHALL count as a boundary event.
REQ-023 A load SHALL set cnt=load_val when load_val<=MAX; otherwise it SHALL set cnt=MAX and set ovf, with no tc.
REQ-024 The ovf flag SHALL be set by any boundary event or clamped load, cleared by ovf_clr, and set SHALL win when both occur on the same edge.
REQ-025 The clr input SHALL set cnt=0, SHALL NOT change ovf, and SHALL force tc=0 on the next cycle.
REQ-026 Arithmetic SHALL be performed at WIDTH+1 bits so that no intermediate truncation occurs when MAX=2**WIDTH-1.

Reset
REQ-027 With rst=1, the next edge SHALL give cnt=0, tc=0, ovf=0 and prescaler=0, regardless of any other input.
REQ-028 A rst mid-count SHALL discard any pending step, load or tc pulse.

Configuration
REQ-029 With PARAM_COUNTER_PRESCALE_EN defined, a prescaler SHALL count cycles with en=1; tick=1 on its PRESCALE-th cycle, after which it wraps to 0.
REQ-030 With PARAM_COUNTER_PRESCALE_EN defined, the prescaler SHALL be cleared by rst, clr or load.
REQ-031 With PARAM_COUNTER_PRESCALE_EN undefined, every en=1 cycle SHALL be a step, PRESCALE SHALL be ignored, and no prescaler flops SHALL exist.

Structure
REQ-032 A shared package param_counter_pkg SHALL hold the mode typedef (wrap/saturate enum) and the width limits.
REQ-033 The prescaler SHALL be a sub-module named param_counter_prescaler, instantiated only under PARAM_COUNTER_PRESCALE_EN.
REQ-034 Illegal parameter values SHALL trigger an elaboration-time error.

Verification (WIDTH=8, MAX=9 unless stated)
REQ-035 Reset, then en=1, up=1 for 12 cycles -> cnt 1..9,0,1,2; tc high only in the cycle after 9->0; ovf=1.
REQ-036 SATURATE=1, cnt=9, up steps for 3 cycles -> cnt stays 9; tc high on 3 consecutive cycles; ovf=1.
REQ-037 cnt=0, up=0, one step -> cnt=9 and tc pulse; ovf_clr together with a new boundary event -> ovf stays 1.
REQ-038 load=1, load_val=200 -> cnt=9, ovf=1, tc=0; load_val=4 with en=1 on the same edge -> cnt=4, no step.
REQ-039 rst at cnt=5 with ovf=1 -> cnt=0, ovf=0, tc=0 next cycle; clr and load on the same edge -> cnt=0.
REQ-040 PARAM_COUNTER_PRESCALE_EN defined, PRESCALE=4, en=1 for 8 cycles -> cnt=2; load mid-window restarts the 4-cycle window.
